// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: the hex segment table,
// the blank segment pattern, the slot states and the output polarity helper.
package seg7_scan_mux_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Segment bit order is [0]=a .. [6]=g. Segments are active-high here.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return HEX_SEG[hex];
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic common_anode);
        return common_anode ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_dec.sv
// Single-digit hex to 7-segment decoder. The output is active-high and is not registered.
module seg7_scan_mux_dec
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] counter,
    output logic [6:0] segments
);

    assign segments = hex_to_seg(counter);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver. It double-buffers the digits, swaps buffers
// at frame boundaries, blanks between digits, and can suppress leading zeros.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 2500,
    parameter int BLANK_CYCLES = 16,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] TICK_LAST   = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] DRIVE_FIRST = TW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam logic          INVERT      = (COMMON_ANODE != 0);

    logic [TW-1:0]           tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    slot_e                   slot_q, slot_d;
    logic                    wrap, wrap_q;
    logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [3:0]              cur_hex;
    logic [6:0]              cur_seg;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    // State register. The slot state follows the tick counter.
    // NOTE: every registered signal uses <= so each flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            idx_q  <= '0;
            slot_q <= SLOT_BLANK;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
            slot_q <= slot_d;
            wrap_q <= wrap;
        end
    end

    // Next state. A slot starts blanked and switches to driving after BLANK_CYCLES ticks.
    // NOTE: each signal gets its default first so that no path through the block infers a latch.
    always_comb begin
        wrap   = (tick_q == TICK_LAST) && (idx_q == IDX_LAST);
        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        idx_d  = idx_q;
        if (tick_q == TICK_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        slot_d = (tick_d < DRIVE_FIRST) ? SLOT_BLANK : SLOT_DRIVE;
    end

    // A load on the wrap cycle goes straight to the active buffer.
    // NOTE: the buffers are ordinary flops, so they are cleared in reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_hex <= '0;
            pend_dp  <= '0;
            act_hex  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_hex <= digits_in;
                pend_dp  <= dp_in;
            end
            if (wrap) begin
                act_hex <= load ? digits_in : pend_hex;
                act_dp  <= load ? dp_in     : pend_dp;
            end
        end
    end

    // lz_mask[i] is set when digit i and every digit above it are zero. Digit 0 is never masked.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (act_hex[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_above;
        end
    end

    assign cur_hex = act_hex[4*idx_q +: 4];

    seg7_scan_mux_dec u_dec (
        .counter  (cur_hex),
        .segments (cur_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        an_d  = '0;
        if (slot_q == SLOT_DRIVE) begin
            an_d[idx_q] = 1'b1;
            seg_d       = (lz_blank && lz_mask[idx_q]) ? SEG_OFF : cur_seg;
            dp_d        = act_dp[idx_q];
        end
    end

    // Polarity is applied at the output register. frame_start lines up with digit 0's first blank cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out     <= seg_polarity(SEG_OFF, INVERT);
            dp_out      <= INVERT;
            an_out      <= {NUM_DIGITS{INVERT}};
            frame_start <= 1'b0;
        end else begin
            seg_out     <= seg_polarity(seg_d, INVERT);
            dp_out      <= dp_d ^ INVERT;
            an_out      <= an_d ^ {NUM_DIGITS{INVERT}};
            frame_start <= wrap_q;
        end
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed driver for an N-digit 7-segment display. It consumes packed 4-bit hex digits, such as the output of the seconds/digit counter, and drives shared segment lines plus per-digit enables. It sits directly downstream of the counter, in place of a single static decoder. Digit updates are double-buffered and applied only at frame boundaries, with inter-digit blanking to suppress ghosting and optional leading-zero suppression.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
REFRESH_DIV, 2500, clk cycles per digit slot (10 MHz gives 4 kHz per slot, 1 kHz per frame); must be > BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all digits disabled; must be >= 1.
COMMON_ANODE, 0, 0 = segment and enable outputs active-high; 1 = both inverted.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
digits_in  input  4*NUM_DIGITS  packed hex digits; [3:0] = digit 0 = rightmost / least significant.
dp_in  input  NUM_DIGITS  decimal point per digit.
load  input  1  single-cycle strobe that captures digits_in/dp_in into the pending buffer.
lz_blank  input  1  enables leading-zero suppression (level, sampled every cycle).
seg_out  output  7  segments, [0]=a .. [6]=g.
dp_out  output  1  decimal-point segment.
an_out  output  NUM_DIGITS  digit enables, one-hot or all-off.
frame_start  output  1  one-cycle pulse when the active buffer is updated.

Behaviour:
- Reset (synchronous, active-high; clk): tick=0, idx=0, pending=0, active=0, dp buffers=0. Outputs: seg_out/dp_out/an_out = "off" (all 0 if COMMON_ANODE=0, all 1 if =1), frame_start=0.
- Slot counter tick counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, tick wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Slot FSM, derived from tick:
  - BLANK when tick < BLANK_CYCLES.
  - DRIVE otherwise.
- Outputs are registered with one cycle of latency from (tick, idx):
  - an_out[idx] active only for ticks in DRIVE.
  - seg_out/dp_out show the decoded active digit during DRIVE and are "off" during BLANK.
  - Exactly one or zero enables are active in any cycle.
- Buffering:
  - load=1 writes pending <= {digits_in, dp_in}.
  - When idx wraps NUM_DIGITS-1 -> 0, active <= pending and frame_start pulses for 1 cycle, registered and aligned with the first BLANK output cycle of digit 0.
  - If load coincides with the wrap cycle, the value loaded that cycle goes to active (bypass).
  - No frame_start at reset release; the first transfer happens at the first wrap.
  - Multiple loads within one frame: the last one wins.
- Leading-zero suppression (lz_blank=1): digit i>0 is blanked (segments off) if its value and all higher digits in active are 0.
  - Digit 0 is never blanked.
  - dp is still driven for a blanked digit; an_out still asserts.
- Decode: standard hex, active-high before polarity.
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- COMMON_ANODE=1 inverts seg_out, dp_out and an_out at the output register.
- Reset mid-frame returns to the reset state on the next edge; pending content is lost.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Duty per digit = (REFRESH_DIV-BLANK_CYCLES)/(NUM_DIGITS*REFRESH_DIV).

Decomposition:
- Shared package holds:
  - SEG_OFF constant.
  - Hex-to-segment lookup constants/function, shared with the existing single-digit decoder.
  - Polarity helper.
- Natural sub-module: the existing seg7 hex decoder (counter[3:0] -> segments[6:0]), instantiated once on the muxed digit.
- The scan counter, FSM, buffers and LZ logic stay in seg7_scan_mux.

Test Plan (bench uses REFRESH_DIV=8, BLANK_CYCLES=2, NUM_DIGITS=4, COMMON_ANODE=0 unless noted):
1. Reset release, no load -> an_out=0000 for cycles 0-2; 0001 for cycles 3-8; 0000 for cycles 9-10; 0010 from cycle 11; seg_out=0x3F while driven; period 32 cycles; no frame_start until cycle 32.
2. load digits_in=0x8A21 at cycle 5 -> digits still show 0 until frame_start; after it, slots show 0x06, 0x5B, 0x77, 0x7F for idx 0..3.
3. lz_blank=1, active=0x0030 -> idx0 seg=0x3F; idx1 seg=0x4F; idx2 and idx3 seg=0x00 with an_out still asserted. Same with active=0x0000 -> only idx0 shows 0x3F.
4. load 0x1111 then 0x2222 in the same frame, plus a load of 0x3333 on the wrap cycle -> the next frame displays 3 on all digits.
5. Assert reset during a DRIVE slot of idx2 -> next cycle all outputs off, and the scan restarts exactly as in scenario 1.
6. COMMON_ANODE=1, active=0x0007 -> driven idx0 gives seg_out=0x78, an_out=1110, dp_out=1. BLANK cycles give seg_out=0x7F, an_out=1111.
